axi4_stream_demux_custom: RTL and testbench

- 1-input, 2-output AXI4-Stream packet router; the fan-out counterpart to the 2:1 switch in the same datapath.
- Destination is selected per packet from one TUSER bit on the first beat, then held until TLAST is accepted.
- Each output has a single registered stage, so input-to-output latency is one cycle.
- All ports share one clock; straddle mode is not supported.

---
 rtl/axi4_stream_demux_custom.sv | 80 ++++++++
 tb/tb_axi4_stream_demux_custom.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_stream_demux_custom.sv
// axi4_stream_demux_custom: 1-to-2 AXI4-Stream packet router with one registered stage per output.
// Define AXIS_DEMUX_DROP_EN to drop packets whose target is disabled at SOP; by default they stall.
module axi4_stream_demux_custom #(
  parameter int TDATA_L   = 512,
  parameter int TUSER_L   = 81,
  parameter int TKEEP_L   = 16,
  parameter int ROUTE_BIT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         m_port_disable,
  input  logic [TDATA_L-1:0] axi_s0_tdata_i,
  input  logic [TUSER_L-1:0] axi_s0_tuser_i,
  input  logic               axi_s0_tlast_i,
  input  logic [TKEEP_L-1:0] axi_s0_tkeep_i,
  input  logic               axi_s0_tvalid_i,
  output logic               axi_s0_tready_o,
  output logic [TDATA_L-1:0] axi_m0_tdata_o,
  output logic [TUSER_L-1:0] axi_m0_tuser_o,
  output logic               axi_m0_tlast_o,
  output logic [TKEEP_L-1:0] axi_m0_tkeep_o,
  output logic               axi_m0_tvalid_o,
  input  logic               axi_m0_tready_i,
  output logic [TDATA_L-1:0] axi_m1_tdata_o,
  output logic [TUSER_L-1:0] axi_m1_tuser_o,
  output logic               axi_m1_tlast_o,
  output logic [TKEEP_L-1:0] axi_m1_tkeep_o,
  output logic               axi_m1_tvalid_o,
  input  logic               axi_m1_tready_i
);
`ifdef AXIS_DEMUX_DROP_EN
  typedef enum logic [1:0] {IDLE, FWD0, FWD1, DROP} state_t;
`else
  typedef enum logic [1:0] {IDLE, FWD0, FWD1} state_t;
`endif
  localparam int PW = TDATA_L + TUSER_L + 1 + TKEEP_L;
  state_t state_q, state_d;
  logic [PW-1:0] pay_q [2];
  logic [1:0] vld_q, rdy, free, wr;
  logic tgt, sop_dis, drop, acc;
  assign rdy  = {axi_m1_tready_i, axi_m0_tready_i};
  assign free = ~vld_q | rdy;
  always_comb begin
    tgt = state_q == FWD1 ? 1'b1 : state_q == FWD0 ? 1'b0 : axi_s0_tuser_i[ROUTE_BIT];
    sop_dis = state_q == IDLE & m_port_disable[tgt];
`ifdef AXIS_DEMUX_DROP_EN
    drop = sop_dis | state_q == DROP;
    axi_s0_tready_o = rst_n & (drop | free[tgt]);
`else
    drop = 1'b0;
    axi_s0_tready_o = rst_n & free[tgt] & ~sop_dis;
`endif
    acc = axi_s0_tvalid_i & axi_s0_tready_o;
    wr = acc & ~drop ? (tgt ? 2'b10 : 2'b01) : 2'b00;
    state_d = state_q;
    if (acc) state_d = axi_s0_tlast_i ? IDLE : state_q != IDLE ? state_q : tgt ? FWD1 : FWD0;
`ifdef AXIS_DEMUX_DROP_EN
    if (acc & sop_dis & ~axi_s0_tlast_i) state_d = DROP;
`endif
  end
  always_ff @(posedge clk)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // Load on accept; otherwise a consumed beat simply empties the register.
  always_ff @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (!rst_n) begin
        vld_q[k] <= 1'b0;
        pay_q[k] <= '0;
      end else if (wr[k]) begin
        vld_q[k] <= 1'b1;
        pay_q[k] <= {axi_s0_tdata_i, axi_s0_tuser_i, axi_s0_tlast_i, axi_s0_tkeep_i};
      end else if (rdy[k]) begin
        vld_q[k] <= 1'b0;
      end
  assign {axi_m0_tdata_o, axi_m0_tuser_o, axi_m0_tlast_o, axi_m0_tkeep_o} = pay_q[0];
  assign {axi_m1_tdata_o, axi_m1_tuser_o, axi_m1_tlast_o, axi_m1_tkeep_o} = pay_q[1];
  assign axi_m0_tvalid_o = vld_q[0];
  assign axi_m1_tvalid_o = vld_q[1];
endmodule

// File: tb/tb_axi4_stream_demux_custom.sv
// tb_axi4_stream_demux_custom: randomized bench with a packet-level routing scoreboard.
module tb_axi4_stream_demux_custom;
  localparam int PW = 512 + 81 + 1 + 16;
  logic clk = 0, rst_n = 0;
  logic [1:0] m_port_disable = 0;
  logic [511:0] s_tdata = 0;
  logic [80:0] s_tuser = 0;
  logic s_tlast = 0, s_tvalid = 0, s_tready;
  logic [15:0] s_tkeep = 0;
  logic [511:0] m0_tdata, m1_tdata;
  logic [80:0] m0_tuser, m1_tuser;
  logic m0_tlast, m1_tlast, m0_tvalid, m1_tvalid;
  logic [15:0] m0_tkeep, m1_tkeep;
  logic m0_tready = 1, m1_tready = 1;
  int tests = 0, failed = 0, cyc = 0;
  int out_cnt [2] = '{0, 0};
  bit rand_on = 0;
  axi4_stream_demux_custom dut (
    .clk(clk), .rst_n(rst_n), .m_port_disable(m_port_disable),
    .axi_s0_tdata_i(s_tdata), .axi_s0_tuser_i(s_tuser), .axi_s0_tlast_i(s_tlast),
    .axi_s0_tkeep_i(s_tkeep), .axi_s0_tvalid_i(s_tvalid), .axi_s0_tready_o(s_tready),
    .axi_m0_tdata_o(m0_tdata), .axi_m0_tuser_o(m0_tuser), .axi_m0_tlast_o(m0_tlast),
    .axi_m0_tkeep_o(m0_tkeep), .axi_m0_tvalid_o(m0_tvalid), .axi_m0_tready_i(m0_tready),
    .axi_m1_tdata_o(m1_tdata), .axi_m1_tuser_o(m1_tuser), .axi_m1_tlast_o(m1_tlast),
    .axi_m1_tkeep_o(m1_tkeep), .axi_m1_tvalid_o(m1_tvalid), .axi_m1_tready_i(m1_tready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always begin
    @(posedge clk);
    #1;
    if (rand_on) begin
      m0_tready = ($urandom % 4) != 0;
      m1_tready = ($urandom % 4) != 0;
      m_port_disable = {($urandom % 5) == 0, ($urandom % 5) == 0};
    end
  end
  wire [PW-1:0] inb = {s_tdata, s_tuser, s_tlast, s_tkeep};
  wire [PW-1:0] ob [2];
  assign ob[0] = {m0_tdata, m0_tuser, m0_tlast, m0_tkeep};
  assign ob[1] = {m1_tdata, m1_tuser, m1_tlast, m1_tkeep};
  wire [1:0] ov = {m1_tvalid, m0_tvalid};
  wire [1:0] orr = {m1_tready, m0_tready};
  // Reference model: packets keep the route chosen at their first beat; each output is an in-order queue.
  logic [PW-1:0] q [2][$];
  logic [PW-1:0] held [2], pend_b, exp_b;
  bit hold [2] = '{0, 0};
  bit in_pkt = 0, cur_rt = 0, dropping = 0, pend_v = 0, pend_p = 0, rt;
  always @(negedge clk) begin
    if (!rst_n) begin
      q[0].delete();
      q[1].delete();
      in_pkt = 0; dropping = 0; pend_v = 0; hold[0] = 0; hold[1] = 0;
      tests++;
      if (s_tready !== 1'b0) begin failed++; $display("FAIL reset_tready got %b exp 0", s_tready); end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (pend_v && pend_p == p) begin
          tests++;
          if (ov[p] !== 1'b1 || ob[p] !== pend_b) begin
            failed++; $display("FAIL latency port%0d valid %b got %h exp %h", p, ov[p], ob[p], pend_b);
          end
        end
        if (hold[p]) begin
          tests++;
          if (ov[p] !== 1'b1 || ob[p] !== held[p]) begin
            failed++; $display("FAIL hold port%0d valid %b got %h exp %h", p, ov[p], ob[p], held[p]);
          end
        end
        if (ov[p] && orr[p]) begin
          tests++;
          if (q[p].size() == 0) begin
            failed++; $display("FAIL spurious port%0d got %h exp none", p, ob[p]);
          end else begin
            exp_b = q[p].pop_front();
            if (ob[p] !== exp_b) begin failed++; $display("FAIL order port%0d got %h exp %h", p, ob[p], exp_b); end
          end
          out_cnt[p]++;
          hold[p] = 0;
        end else if (ov[p]) begin
          hold[p] = 1; held[p] = ob[p];
        end else hold[p] = 0;
      end
      pend_v = 0;
      if (s_tvalid && s_tready) begin
        rt = in_pkt ? cur_rt : s_tuser[0];
        if (!in_pkt) begin
          dropping = m_port_disable[rt];
`ifndef AXIS_DEMUX_DROP_EN
          tests++;
          if (dropping) begin failed++; $display("FAIL sop_disabled_accept got 1 exp 0"); end
          dropping = 0;
`endif
        end
        if (!dropping) begin
          q[rt].push_back(inb);
          pend_v = 1; pend_p = rt; pend_b = inb;
        end
        cur_rt = rt;
        in_pkt = !s_tlast;
        if (s_tlast) dropping = 0;
      end
    end
  end
  task automatic send_beat(input logic rb, input logic last);
    logic [95:0] t;
    bit got = 0;
    t = {$urandom, $urandom, $urandom};
    s_tdata = {16{$urandom}};
    s_tuser = t[80:0];
    s_tuser[0] = rb;
    s_tkeep = t[95:80];
    s_tlast = last;
    s_tvalid = 1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = s_tready;
    end
    tests++;
    if (!got) begin failed++; $display("FAIL accept_timeout got tready 0 exp 1"); end
    @(posedge clk);
    #1;
    s_tvalid = 0;
  endtask
  task automatic send_pkt(input logic route, input int len, input bit toggle);
    for (int i = 0; i < len; i++)
      send_beat((toggle && (i == 1 || i == 2)) ? ~route : route, i == len - 1);
  endtask
  task automatic drain();
    m0_tready = 1; m1_tready = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!m0_tvalid && !m1_tvalid) break;
    end
    @(posedge clk);
    #1;
    tests++;
    if (m0_tvalid || m1_tvalid || q[0].size() != 0 || q[1].size() != 0) begin
      failed++; $display("FAIL drain valid %b%b queued %0d/%0d exp 00 0/0", m1_tvalid, m0_tvalid, q[1].size(), q[0].size());
    end
  endtask
  task automatic test_reset();
    rst_n = 0;
    send_beat_nowait();
    repeat (2) @(posedge clk);
    #1;
    tests += 6;
    if (s_tready !== 1'b0) begin failed++; $display("FAIL rst_tready got %b exp 0", s_tready); end
    if ({m1_tvalid, m0_tvalid} !== 2'b00) begin failed++; $display("FAIL rst_tvalid got %b exp 00", {m1_tvalid, m0_tvalid}); end
    if ({m1_tlast, m0_tlast} !== 2'b00) begin failed++; $display("FAIL rst_tlast got %b exp 00", {m1_tlast, m0_tlast}); end
    if ((m0_tdata | m1_tdata) !== '0) begin failed++; $display("FAIL rst_tdata got %h exp 0", m0_tdata | m1_tdata); end
    if ((m0_tuser | m1_tuser) !== '0) begin failed++; $display("FAIL rst_tuser got %h exp 0", m0_tuser | m1_tuser); end
    if ((m0_tkeep | m1_tkeep) !== '0) begin failed++; $display("FAIL rst_tkeep got %h exp 0", m0_tkeep | m1_tkeep); end
    rst_n = 1;
    s_tvalid = 0;
  endtask
  task automatic send_beat_nowait();
    s_tdata = {16{$urandom}};
    s_tlast = 1;
    s_tvalid = 1;
  endtask
  task automatic test_single_m1();
    int c0 = out_cnt[0], c1 = out_cnt[1];
    send_pkt(1, 4, 0);
    drain();
    tests++;
    if (out_cnt[1] - c1 != 4 || out_cnt[0] != c0) begin
      failed++; $display("FAIL single_m1 got m0 %0d m1 %0d exp 0 4", out_cnt[0] - c0, out_cnt[1] - c1);
    end
  endtask
  task automatic test_back_to_back();
    int c0 = out_cnt[0], c1 = out_cnt[1], t0 = cyc;
    send_pkt(0, 3, 0);
    send_pkt(1, 2, 0);
    tests++;
    if (cyc - t0 != 5) begin failed++; $display("FAIL b2b_cycles got %0d exp 5", cyc - t0); end
    drain();
    tests++;
    if (out_cnt[0] - c0 != 3 || out_cnt[1] - c1 != 2) begin
      failed++; $display("FAIL b2b_counts got m0 %0d m1 %0d exp 3 2", out_cnt[0] - c0, out_cnt[1] - c1);
    end
  endtask
  task automatic test_stall();
    int c0 = out_cnt[0];
    fork
      send_pkt(0, 6, 0);
      begin
        repeat (2) @(posedge clk);
        #1;
        m0_tready = 0;
        repeat (5) begin
          @(negedge clk);
          tests++;
          if (s_tready !== 1'b0 || m1_tvalid !== 1'b0) begin
            failed++; $display("FAIL stall got tready %b m1_valid %b exp 0 0", s_tready, m1_tvalid);
          end
        end
        @(posedge clk);
        #1;
        m0_tready = 1;
      end
    join
    drain();
    tests++;
    if (out_cnt[0] - c0 != 6) begin failed++; $display("FAIL stall_count got %0d exp 6", out_cnt[0] - c0); end
  endtask
  task automatic test_route_toggle();
    int c0 = out_cnt[0], c1 = out_cnt[1];
    send_pkt(0, 4, 1);
    drain();
    tests++;
    if (out_cnt[0] - c0 != 4 || out_cnt[1] != c1) begin
      failed++; $display("FAIL toggle got m0 %0d m1 %0d exp 4 0", out_cnt[0] - c0, out_cnt[1] - c1);
    end
  endtask
  task automatic test_disable();
    int c0 = out_cnt[0], c1 = out_cnt[1], t0;
    m_port_disable = 2'b01;
`ifdef AXIS_DEMUX_DROP_EN
    t0 = cyc;
    send_pkt(0, 3, 0);
    tests++;
    if (cyc - t0 != 3) begin failed++; $display("FAIL drop_cycles got %0d exp 3", cyc - t0); end
    m_port_disable = 0;
    repeat (2) begin
      @(negedge clk);
      tests++;
      if (m0_tvalid !== 1'b0 || m1_tvalid !== 1'b0) begin
        failed++; $display("FAIL drop_valid got %b%b exp 00", m1_tvalid, m0_tvalid);
      end
    end
    drain();
    tests++;
    if (out_cnt[0] != c0 || out_cnt[1] != c1) begin
      failed++; $display("FAIL drop_count got m0 %0d m1 %0d exp 0 0", out_cnt[0] - c0, out_cnt[1] - c1);
    end
`else
    t0 = 0;
    fork
      send_pkt(0, 3, 0);
      begin
        repeat (6) begin
          @(negedge clk);
          tests++;
          if (s_tready !== 1'b0) begin failed++; $display("FAIL disable_stall got tready %b exp 0", s_tready); end
        end
        @(posedge clk);
        #1;
        m_port_disable = 0;
      end
    join
    drain();
    tests++;
    if (out_cnt[0] - c0 != 3 + t0 || out_cnt[1] != c1) begin
      failed++; $display("FAIL disable_count got m0 %0d m1 %0d exp 3 0", out_cnt[0] - c0, out_cnt[1] - c1);
    end
`endif
  endtask
  task automatic test_reset_mid();
    int c1 = out_cnt[1];
    send_beat(0, 0);
    send_beat(0, 0);
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    tests++;
    if (m0_tvalid !== 1'b0 || m1_tvalid !== 1'b0 || m0_tlast !== 1'b0) begin
      failed++; $display("FAIL mid_reset got valid %b%b tlast %b exp 00 0", m1_tvalid, m0_tvalid, m0_tlast);
    end
    send_pkt(1, 3, 0);
    drain();
    tests++;
    if (out_cnt[1] - c1 != 3) begin failed++; $display("FAIL mid_reset_sop got m1 %0d exp 3", out_cnt[1] - c1); end
  endtask
  task automatic test_random();
    rand_on = 1;
    repeat (80) begin
      send_pkt(1'($urandom % 2), 1 + int'($urandom % 5), bit'($urandom % 2));
      repeat ($urandom % 3) begin @(posedge clk); #1; end
    end
    rand_on = 0;
    #1;
    m_port_disable = 0;
    drain();
  endtask
  initial begin
    test_reset();
    test_single_m1();
    test_back_to_back();
    test_stall();
    test_route_toggle();
    test_disable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
